// File: rtl/result_formatter.sv
// Converts a captured 32-bit ALU result to an ASCII hex line streamed over valid/ready.
// Optional build macro: FMT_ZERO_SUPPRESS_EN (skip leading zero digits).
module result_formatter #(
  parameter int NUM_DIGITS = 8,
  parameter int EOL_CRLF   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_done,
  input  logic [31:0] calc_res,
  input  logic [3:0]  dtype,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        fmt_done,
  output logic        drop
);

  localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_SIGN, S_DIGIT, S_CR, S_LF} state_t;

  state_t          state_q, state_d;
  logic [31:0]     val_q, val_d;
  logic            neg_q, neg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            busy_q, busy_d;
  logic            fmt_done_q, fmt_done_d;
  logic            drop_q, drop_d;

  logic            accept;
  logic            cap_neg;
  logic [31:0]     cap_mag;
  logic [CW-1:0]   cap_first;
  logic [CW-1:0]   val_first;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Counter value c selects the c-th digit counted from the most significant one.
  function automatic logic [3:0] nibble_at(input logic [31:0] v, input logic [CW-1:0] c);
    logic [31:0] t;
    t = v >> (4 * (NUM_DIGITS - 1 - int'(c)));
    return t[3:0];
  endfunction

  function automatic logic [CW-1:0] first_digit(input logic [31:0] v);
`ifdef FMT_ZERO_SUPPRESS_EN
    logic [CW-1:0] f;
    logic          found;
    f     = LAST_DIGIT;
    found = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!found && nibble_at(v, CW'(i)) != 4'h0) begin
        f     = CW'(i);
        found = 1'b1;
      end
    end
    return f;
`else
    return (v == v) ? '0 : '0;
`endif
  endfunction

  assign accept    = tx_valid_q & tx_ready;
  assign cap_neg   = (dtype == 4'h1) & calc_res[31];
  assign cap_mag   = cap_neg ? (~calc_res + 32'd1) : calc_res;
  assign cap_first = first_digit(cap_mag);
  assign val_first = first_digit(val_q);

  always_comb begin
    state_d    = state_q;
    val_d      = val_q;
    neg_d      = neg_q;
    cnt_d      = cnt_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    fmt_done_d = 1'b0;
    drop_d     = alu_done & busy_q;

    case (state_q)
      S_IDLE: begin
        if (alu_done) begin
          neg_d      = cap_neg;
          val_d      = cap_mag;
          busy_d     = 1'b1;
          tx_valid_d = 1'b1;
          if (cap_neg) begin
            state_d   = S_SIGN;
            tx_data_d = 8'h2D;
          end else begin
            state_d   = S_DIGIT;
            cnt_d     = cap_first;
            tx_data_d = hex_ascii(nibble_at(cap_mag, cap_first));
          end
        end
      end
      S_SIGN: begin
        if (accept) begin
          state_d   = S_DIGIT;
          cnt_d     = val_first;
          tx_data_d = hex_ascii(nibble_at(val_q, val_first));
        end
      end
      S_DIGIT: begin
        if (accept) begin
          if (cnt_q == LAST_DIGIT) begin
            cnt_d = '0;
            if (EOL_CRLF != 0) begin
              state_d   = S_CR;
              tx_data_d = 8'h0D;
            end else begin
              state_d   = S_LF;
              tx_data_d = 8'h0A;
            end
          end else begin
            cnt_d     = cnt_q + 1'b1;
            tx_data_d = hex_ascii(nibble_at(val_q, cnt_q + 1'b1));
          end
        end
      end
      S_CR: begin
        if (accept) begin
          state_d   = S_LF;
          tx_data_d = 8'h0A;
        end
      end
      S_LF: begin
        // Terminator accepted: free the block so a new result can be captured next cycle.
        if (accept) begin
          state_d    = S_IDLE;
          tx_valid_d = 1'b0;
          tx_data_d  = 8'h00;
          busy_d     = 1'b0;
          fmt_done_d = 1'b1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      val_q      <= 32'h0;
      neg_q      <= 1'b0;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      fmt_done_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      val_q      <= val_d;
      neg_q      <= neg_d;
      cnt_q      <= cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      fmt_done_q <= fmt_done_d;
      drop_q     <= drop_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign fmt_done = fmt_done_q;
  assign drop     = drop_q;

endmodule

// File: tb/tb_result_formatter.sv
// Self-checking bench for result_formatter: directed cases plus random results/backpressure
// compared against a string-building reference model.
module tb_result_formatter;
  localparam int NUM_DIGITS = 8;
  localparam int EOL_CRLF   = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_done;
  logic [31:0] calc_res;
  logic [3:0]  dtype;
  logic        tx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        busy;
  logic        fmt_done;
  logic        drop;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  result_formatter #(.NUM_DIGITS(NUM_DIGITS), .EOL_CRLF(EOL_CRLF)) dut (
    .clk(clk), .rst(rst), .alu_done(alu_done), .calc_res(calc_res), .dtype(dtype),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .busy(busy),
    .fmt_done(fmt_done), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: print |value| in base 16 with one character per digit, then the line ending.
  function automatic void build(input logic [31:0] r, input logic [3:0] dt);
    string hx;
    longint unsigned mag, p;
    bit neg;
    int d;
`ifdef FMT_ZERO_SUPPRESS_EN
    bit lead;
    lead = 1'b1;
`endif
    hx = "0123456789ABCDEF";
    exp_q.delete();
    neg = (dt == 4'h1) && r[31];
    mag = neg ? (64'd4294967296 - {32'h0, r}) : {32'h0, r};
    if (neg) exp_q.push_back(8'h2D);
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      p = 64'd1 << (4 * k);
      d = int'((mag / p) % 64'd16);
`ifdef FMT_ZERO_SUPPRESS_EN
      if (lead && d == 0 && k > 0) continue;
      lead = 1'b0;
`endif
      exp_q.push_back(hx[d]);
    end
    if (EOL_CRLF != 0) exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  // mode 0: always ready, 1: random ready, 2: ready low 5 cycles on byte index 2.
  // coll_at >= 0 raises a second alu_done while that byte index is on the bus.
  task automatic send(input logic [31:0] r, input logic [3:0] dt, input int mode, input int coll_at);
    int n = 0, stall = 0, budget = 0, coll_phase = 0, nb;
    logic pv = 1'b0, pr = 1'b0;
    logic [7:0] pd = 8'h00;
    build(r, dt);
    nb = exp_q.size();
    alu_done = 1'b1; calc_res = r; dtype = dt; tx_ready = 1'b1;
    @(posedge clk); #1;
    alu_done = 1'b0; calc_res = $urandom;
    chk("busy_rise", {31'h0, busy}, 32'd1);
    chk("first_valid", {31'h0, tx_valid}, 32'd1);
    chk("fmt_done_once", {31'h0, fmt_done}, 32'd0);
    chk("no_drop_on_capture", {31'h0, drop}, 32'd0);
    while (exp_q.size() > 0 && budget < 400) begin
      budget++;
      if (pv && !pr) begin
        chk("hold_valid", {31'h0, tx_valid}, 32'd1);
        chk("hold_data", {24'h0, tx_data}, {24'h0, pd});
      end
      case (mode)
        0: tx_ready = 1'b1;
        1: tx_ready = 1'($urandom_range(0, 1));
        default: begin
          if (n == 2 && stall < 5) begin tx_ready = 1'b0; stall++; end
          else tx_ready = 1'b1;
        end
      endcase
      if (coll_phase == 0 && n == coll_at) begin
        alu_done = 1'b1; calc_res = 32'hDEADBEEF; dtype = 4'h2; coll_phase = 1;
      end
      if (tx_valid && tx_ready) begin
        chk("byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
        n++;
      end
      pv = tx_valid; pr = tx_ready; pd = tx_data;
      @(posedge clk); #1;
      if (coll_phase == 1) begin
        alu_done = 1'b0;
        chk("drop_pulse", {31'h0, drop}, 32'd1);
        coll_phase = 2;
      end else if (coll_phase == 2) begin
        chk("drop_once", {31'h0, drop}, 32'd0);
        coll_phase = 3;
      end
    end
    chk("string_complete", exp_q.size(), 32'd0);
    chk("fmt_done", {31'h0, fmt_done}, 32'd1);
    chk("busy_fall", {31'h0, busy}, 32'd0);
    chk("valid_low", {31'h0, tx_valid}, 32'd0);
    $display("string res=%08h dtype=%0h mode=%0d bytes=%0d cycles=%0d", r, dt, mode, nb, budget);
  endtask

  initial begin
    logic [31:0] rv;
    rst = 1'b1; alu_done = 1'b0; calc_res = 32'h0; dtype = 4'h0; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_fmt_done", {31'h0, fmt_done}, 32'd0);
    chk("rst_drop", {31'h0, drop}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    send(32'h1234ABCD, 4'h2, 0, -1);
    send(32'hFFFFFFFE, 4'h1, 0, -1);
    send(32'h80000000, 4'h1, 0, -1);
    send(32'h00000000, 4'h2, 0, -1);
    send(32'h00000000, 4'h1, 0, -1);
    send(32'hFFFFFFFE, 4'h2, 0, -1);
    send(32'h1234ABCD, 4'h2, 2, -1);
    send(32'h00000001, 4'h2, 0, 2);

    // Abort a string after three accepted bytes.
    @(posedge clk); #1;
    alu_done = 1'b1; calc_res = 32'h1234ABCD; dtype = 4'h2; tx_ready = 1'b1;
    @(posedge clk); #1;
    alu_done = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_rst_busy", {31'h0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'h0, tx_valid}, 32'd0);
    chk("mid_rst_busy", {31'h0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_valid", {31'h0, tx_valid}, 32'd0);
    send(32'h0000000F, 4'h2, 0, -1);

    for (int i = 0; i < 24; i++) begin
      rv = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rv = ~rv;
      case ($urandom_range(0, 2))
        0: dtype = 4'h1;
        1: dtype = 4'h2;
        default: dtype = 4'($urandom);
      endcase
      send(rv, dtype, 1, (i % 4 == 0) ? int'($urandom_range(0, 5)) : -1);
      if (i % 3 == 0) begin
        tx_ready = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        chk("idle_valid", {31'h0, tx_valid}, 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
